// File: rtl/replace_num_msg_rx_pkg.sv
// +------------------------------------------------------------------+
// | replace_num_msg_rx_pkg : shared REPLACE_NUM message constants     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package replace_num_msg_rx_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 8;
  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam logic [7:0]  DEF_MSG_ID         = 8'h52;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

  // Payload bytes carried by one message; the memory decodes the same {addr, data} layout.
  function automatic int unsigned payload_bytes(input int unsigned aw, input int unsigned dw);
    return (aw + dw) / 8;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/replace_num_msg_rx_timer.sv
// +------------------------------------------------------------------+
// | replace_num_msg_rx_timer : inter-byte timeout counter             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module replace_num_msg_rx_timer
  import replace_num_msg_rx_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates at LAST so a stalled owner never sees the flag wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/replace_num_msg_rx.sv
// +------------------------------------------------------------------+
// | replace_num_msg_rx : UART REPLACE_NUM parser -> memory write      |
// | Option macro: UART_REPLACE_NUM_CHECKSUM_EN (trailing XOR byte)    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module replace_num_msg_rx
  import replace_num_msg_rx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter logic [7:0]  MSG_ID         = DEF_MSG_ID,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
  output logic                             wr_en,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned   PW       = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned   NBYTES   = payload_bytes(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned   CW       = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] shift_q, shift_d;
  logic [PW-1:0] wr_packet_q, wr_packet_d;
  logic          wr_en_q, wr_en_d;
  logic          err_q, err_d;
  logic [PW-1:0] w_shift_next;
  logic          w_counting;
  logic          w_expired;
  logic          w_timeout;
  logic          w_csum_fail;

  generate
    if (PW > 8) begin : g_shift_wide
      assign w_shift_next = {shift_q[PW-9:0], rx_data};
    end else begin : g_shift_byte
      assign w_shift_next = rx_data;
    end
  endgenerate

  assign w_counting = (state_q == PAYLOAD) || (state_q == CHECK);
  assign w_timeout  = w_counting && !rx_valid && w_expired;

  replace_num_msg_rx_timer #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (!w_counting || rx_valid),
    .enable  (w_counting && !rx_valid),
    .expired (w_expired)
  );

`ifdef UART_REPLACE_NUM_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign w_csum_fail = (state_q == CHECK) && rx_valid && (rx_data != csum_q);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`else
  assign w_csum_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_packet_q <= '0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wr_packet_q <= wr_packet_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
    end
  end

  // Header bytes inside the payload are plain data; only IDLE looks for MSG_ID.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef UART_REPLACE_NUM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == MSG_ID)) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
`ifdef UART_REPLACE_NUM_CHECKSUM_EN
          csum_d  = MSG_ID;
`endif
        end
      end
      PAYLOAD: begin
        if (w_timeout) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          shift_d = w_shift_next;
          cnt_d   = cnt_q + 1'b1;
`ifdef UART_REPLACE_NUM_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          if (cnt_q == LAST_CNT) state_d = CHECK;
`else
          if (cnt_q == LAST_CNT) state_d = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef UART_REPLACE_NUM_CHECKSUM_EN
        if (w_timeout) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // DONE lasts one cycle, so wr_en can never be asserted on back-to-back cycles.
  always_comb begin
    wr_en_d     = (state_q == DONE);
    wr_packet_d = (state_q == DONE) ? shift_q : wr_packet_q;
    err_d       = w_timeout || w_csum_fail;
  end

  assign wr_packet = wr_packet_q;
  assign wr_en     = wr_en_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
